// File: rtl/branch_controller_if.sv
// Signal bundle between the pipeline and the branch controller.
// Covers the IF lookup, the EX resolve inputs, and the flush/redirect/statistics outputs.
interface branch_controller_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic [2:0]  ex_func3;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic        ex_pred_taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output if_pc, ex_valid, ex_branch, ex_func3, ex_rs1, ex_rs2,
               ex_pc, ex_imm, ex_pred_taken,
        input  pred_taken, flush, redirect_pc, branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_branch, ex_func3, ex_rs1, ex_rs2,
               ex_pc, ex_imm, ex_pred_taken,
        output pred_taken, flush, redirect_pc, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_controller.sv
// EX-stage branch resolution with a direct-mapped table of 2-bit saturating counters.
// Mispredicts raise a registered one-cycle flush carrying the corrected fetch PC.
module branch_controller #(
    parameter int BHT_ENTRIES = 16
) (
    input logic          clk,
    input logic          rst,
    branch_controller_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Saturating 2-bit counter step toward the observed outcome.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

    // Saturating 32-bit increment.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [1:0]       bht_r [BHT_ENTRIES];
    logic             flush_r;
    logic [31:0]      redirect_r;
    logic [31:0]      branch_count_r;
    logic [31:0]      mispredict_count_r;

    logic [IDX_W-1:0] lookup_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic             cond_s;
    logic             legal_s;
    logic             resolve_s;
    logic             mispredict_s;
    logic [31:0]      target_s;
    logic [1:0]       upd_ctr_s;
    logic             unused_s;

    assign lookup_idx_s = bus.if_pc[IDX_W+1:2];
    assign upd_idx_s    = bus.ex_pc[IDX_W+1:2];
    assign unused_s     = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};

    // Branch condition evaluation; only BLT/BGE compare as signed.
    always_comb begin
        cond_s  = 1'b0;
        legal_s = 1'b1;
        case (bus.ex_func3)
            3'b000:  cond_s = (bus.ex_rs1 == bus.ex_rs2);
            3'b001:  cond_s = (bus.ex_rs1 != bus.ex_rs2);
            3'b100:  cond_s = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            3'b101:  cond_s = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            3'b110:  cond_s = (bus.ex_rs1 <  bus.ex_rs2);
            3'b111:  cond_s = (bus.ex_rs1 >= bus.ex_rs2);
            default: legal_s = 1'b0;
        endcase
    end

    // Resolve qualification and corrected target; EX is wrong-path while flush is high.
    always_comb begin
        resolve_s    = bus.ex_valid & bus.ex_branch & legal_s & ~flush_r;
        mispredict_s = resolve_s & (cond_s != bus.ex_pred_taken);
        upd_ctr_s    = ctr_step(bht_r[upd_idx_s], cond_s);
        if (cond_s) begin
            target_s = bus.ex_pc + bus.ex_imm;
        end else begin
            target_s = bus.ex_pc + 32'd4;
        end
    end

    // Prediction table: weakly not-taken after reset, trained on each resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (resolve_s) begin
            bht_r[upd_idx_s] <= upd_ctr_s;
        end
    end

    // Flush pulse and redirect target; redirect holds its value between mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_r    <= 1'b0;
            redirect_r <= 32'h0000_0000;
        end else begin
            flush_r <= mispredict_s;
            if (mispredict_s) begin
                redirect_r <= target_s;
            end
        end
    end

    // Branch and mispredict statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_r     <= 32'd0;
            mispredict_count_r <= 32'd0;
        end else begin
            if (resolve_s) begin
                branch_count_r <= sat_inc(branch_count_r);
            end
            if (mispredict_s) begin
                mispredict_count_r <= sat_inc(mispredict_count_r);
            end
        end
    end

    assign bus.pred_taken       = bht_r[lookup_idx_s][1];
    assign bus.flush            = flush_r;
    assign bus.redirect_pc      = redirect_r;
    assign bus.branch_count     = branch_count_r;
    assign bus.mispredict_count = mispredict_count_r;
endmodule

// File: tb/tb_branch_controller.sv
// Directed-vector bench for branch_controller: table of per-cycle stimulus with
// hand-computed results, followed by reset, same-index and wrap-around sequences.
module tb_branch_controller;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    branch_controller_if bc_if ();

    branch_controller #(.BHT_ENTRIES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bc_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        branch;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pt;
        logic [31:0] ifpc;
        logic        e_flush;
        logic        chk_rd;
        logic [31:0] e_rd;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
        logic        e_pred;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ifpc);
        bc_if.ex_valid      = v;
        bc_if.ex_branch     = b;
        bc_if.ex_func3      = f3;
        bc_if.ex_rs1        = rs1;
        bc_if.ex_rs2        = rs2;
        bc_if.ex_pc         = pc;
        bc_if.ex_imm        = imm;
        bc_if.ex_pred_taken = pt;
        bc_if.if_pc         = ifpc;
    endtask

    task automatic idle(input logic [31:0] ifpc);
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, ifpc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_not_taken(input string name);
        for (int i = 0; i < 16; i++) begin
            bc_if.if_pc = 32'h0000_1000 + 32'(i * 4);
            #1;
            chk(name, {31'd0, bc_if.pred_taken}, 32'd0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        //        v     b     f3      rs1            rs2           pc             imm           pt    ifpc           fl    crd   rd             bc      mc     pred
        vecs[0]  = '{1'b1, 1'b1, 3'b000, 32'd5,         32'd5,        32'h0000_0100, 32'h0000_0020, 1'b0, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0120, 32'd1,  32'd1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 3'b000, 32'd0,         32'd0,        32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0000, 32'd1,  32'd1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1,        32'h0000_0204, 32'h0000_0010, 1'b1, 32'h0000_0204, 1'b0, 1'b0, 32'h0000_0000, 32'd2,  32'd1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1,        32'h0000_0208, 32'h0000_0010, 1'b0, 32'h0000_0208, 1'b0, 1'b0, 32'h0000_0000, 32'd3,  32'd1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1,        32'h0000_0208, 32'h0000_0010, 1'b1, 32'h0000_0208, 1'b1, 1'b1, 32'h0000_020C, 32'd4,  32'd2, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 3'b000, 32'd0,         32'd0,        32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_030C, 1'b0, 1'b0, 32'h0000_0000, 32'd4,  32'd2, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'b001, 32'd1,         32'd2,        32'h0000_030C, 32'h0000_0008, 1'b1, 32'h0000_030C, 1'b0, 1'b0, 32'h0000_0000, 32'd5,  32'd2, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 3'b001, 32'd1,         32'd2,        32'h0000_030C, 32'h0000_0008, 1'b1, 32'h0000_030C, 1'b0, 1'b0, 32'h0000_0000, 32'd6,  32'd2, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 3'b001, 32'd1,         32'd2,        32'h0000_030C, 32'h0000_0008, 1'b1, 32'h0000_030C, 1'b0, 1'b0, 32'h0000_0000, 32'd7,  32'd2, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 3'b001, 32'd1,         32'd2,        32'h0000_030C, 32'h0000_0008, 1'b1, 32'h0000_030C, 1'b0, 1'b0, 32'h0000_0000, 32'd8,  32'd2, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 3'b001, 32'd7,         32'd7,        32'h0000_030C, 32'h0000_0008, 1'b0, 32'h0000_030C, 1'b0, 1'b0, 32'h0000_0000, 32'd9,  32'd2, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 3'b001, 32'd7,         32'd7,        32'h0000_030C, 32'h0000_0008, 1'b0, 32'h0000_030C, 1'b0, 1'b0, 32'h0000_0000, 32'd10, 32'd2, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 3'b001, 32'd7,         32'd7,        32'h0000_030C, 32'h0000_0008, 1'b0, 32'h0000_030C, 1'b0, 1'b0, 32'h0000_0000, 32'd11, 32'd2, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 3'b001, 32'd7,         32'd7,        32'h0000_030C, 32'h0000_0008, 1'b0, 32'h0000_030C, 1'b0, 1'b0, 32'h0000_0000, 32'd12, 32'd2, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 3'b101, 32'd5,         32'd3,        32'h0000_0410, 32'h0000_0040, 1'b0, 32'h0000_0410, 1'b1, 1'b1, 32'h0000_0450, 32'd13, 32'd3, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 3'b111, 32'd1,         32'd2,        32'h0000_0414, 32'h0000_0040, 1'b1, 32'h0000_0414, 1'b0, 1'b0, 32'h0000_0000, 32'd13, 32'd3, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 3'b111, 32'd1,         32'd2,        32'h0000_0414, 32'h0000_0040, 1'b1, 32'h0000_0414, 1'b1, 1'b1, 32'h0000_0418, 32'd14, 32'd4, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 3'b000, 32'd0,         32'd0,        32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0414, 1'b0, 1'b0, 32'h0000_0000, 32'd14, 32'd4, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 3'b010, 32'd3,         32'd3,        32'h0000_0418, 32'h0000_0040, 1'b1, 32'h0000_0418, 1'b0, 1'b0, 32'h0000_0000, 32'd14, 32'd4, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 3'b011, 32'd3,         32'd3,        32'h0000_041C, 32'h0000_0040, 1'b1, 32'h0000_041C, 1'b0, 1'b0, 32'h0000_0000, 32'd14, 32'd4, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 3'b000, 32'd3,         32'd3,        32'h0000_0420, 32'h0000_0040, 1'b1, 32'h0000_0420, 1'b0, 1'b0, 32'h0000_0000, 32'd14, 32'd4, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 3'b000, 32'd3,         32'd3,        32'h0000_0420, 32'h0000_0040, 1'b0, 32'h0000_0420, 1'b0, 1'b0, 32'h0000_0000, 32'd14, 32'd4, 1'b0};
        vecs[22] = '{1'b1, 1'b1, 3'b000, 32'h8000_0000, 32'd0,        32'h0000_0420, 32'h0000_0040, 1'b0, 32'h0000_0420, 1'b0, 1'b0, 32'h0000_0000, 32'd15, 32'd4, 1'b0};

        idle(32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_flush", {31'd0, bc_if.flush}, 32'd0);
        chk("reset_redirect", bc_if.redirect_pc, 32'h0000_0000);
        chk("reset_bcount", bc_if.branch_count, 32'd0);
        chk("reset_mcount", bc_if.mispredict_count, 32'd0);
        check_all_not_taken("reset_pred");

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].valid, vecs[i].branch, vecs[i].f3, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].pc, vecs[i].imm, vecs[i].pt, vecs[i].ifpc);
            step();
            chk($sformatf("v%0d_flush", i), {31'd0, bc_if.flush}, {31'd0, vecs[i].e_flush});
            if (vecs[i].chk_rd) begin
                chk($sformatf("v%0d_redirect", i), bc_if.redirect_pc, vecs[i].e_rd);
            end
            chk($sformatf("v%0d_bcount", i), bc_if.branch_count, vecs[i].e_bc);
            chk($sformatf("v%0d_mcount", i), bc_if.mispredict_count, vecs[i].e_mc);
            chk($sformatf("v%0d_pred", i), {31'd0, bc_if.pred_taken}, {31'd0, vecs[i].e_pred});
        end

        // Same-index read/write: counter[0] is 10, a not-taken BEQ moves it to 01.
        drive(1'b1, 1'b1, 3'b000, 32'd1, 32'd2, 32'h0000_0500, 32'h0000_0040, 1'b0, 32'h0000_0500);
        #1;
        chk("same_idx_pre", {31'd0, bc_if.pred_taken}, 32'd1);
        step();
        chk("same_idx_post", {31'd0, bc_if.pred_taken}, 32'd0);
        chk("same_idx_flush", {31'd0, bc_if.flush}, 32'd0);
        chk("same_idx_bcount", bc_if.branch_count, 32'd16);

        // Reset sampled on the edge where a mispredict resolves cancels the flush.
        drive(1'b1, 1'b1, 3'b000, 32'd9, 32'd9, 32'h0000_0100, 32'h0000_0020, 1'b0, 32'h0000_0100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(32'd0);
        chk("rst_cancel_flush", {31'd0, bc_if.flush}, 32'd0);
        chk("rst_cancel_redirect", bc_if.redirect_pc, 32'h0000_0000);
        chk("rst_cancel_bcount", bc_if.branch_count, 32'd0);
        chk("rst_cancel_mcount", bc_if.mispredict_count, 32'd0);
        check_all_not_taken("rst_cancel_pred");
        step();
        chk("rst_cancel_flush2", {31'd0, bc_if.flush}, 32'd0);

        // Taken target wraps modulo 2^32, and the flush lasts one cycle.
        drive(1'b1, 1'b1, 3'b000, 32'd4, 32'd4, 32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 32'hFFFF_FFF0);
        step();
        idle(32'hFFFF_FFF0);
        chk("wrap_flush", {31'd0, bc_if.flush}, 32'd1);
        chk("wrap_redirect", bc_if.redirect_pc, 32'h0000_0010);
        chk("wrap_bcount", bc_if.branch_count, 32'd1);
        chk("wrap_mcount", bc_if.mispredict_count, 32'd1);
        chk("wrap_pred", {31'd0, bc_if.pred_taken}, 32'd1);
        step();
        chk("wrap_flush_end", {31'd0, bc_if.flush}, 32'd0);
        chk("wrap_redirect_hold", bc_if.redirect_pc, 32'h0000_0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
